// File: rtl/bidir_sweep_ctrl_pkg.sv
// Shared types and constants for the bidirectional sweep controller.
package bidir_sweep_ctrl_pkg;

    localparam int unsigned DEFAULT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/bidir_sweep_ctrl_updown_cnt.sv
// Up/down counter datapath: load has priority over counting, and clr over both.
module updown_cnt
    import bidir_sweep_ctrl_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         mode,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = mode ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/bidir_sweep_ctrl.sv
// Sweep controller: counts lo->hi->lo a requested number of times (0 = until stop).
module bidir_sweep_ctrl
    import bidir_sweep_ctrl_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic [3:0]   cycles,
    output logic [W-1:0] q,
    output logic         mode,
    output logic         busy,
    output logic         done,
    output logic         err
);

    sweep_state_t state_q, state_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] hi_q, hi_d;
    logic [3:0]   rem_q, rem_d;
    logic         mode_q, mode_d;
    logic         err_q, err_d;

    logic         cnt_load;
    logic         cnt_en;
    logic         cnt_dir;
    logic [W-1:0] cnt_val;

    updown_cnt #(.W(W)) u_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (lo),
        .en       (cnt_en),
        .mode     (cnt_dir),
        .q        (cnt_val)
    );

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_dir  = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (lo > hi) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d     = lo;
                        hi_d     = hi;
                        rem_d    = cycles;
                        cnt_load = 1'b1;
                        mode_d   = 1'b1;
                        state_d  = (lo == hi) ? ST_DONE : ST_UP;
                    end
                end
            end
            ST_UP: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (cnt_val < hi_q) begin
                    cnt_en  = 1'b1;
                    cnt_dir = 1'b1;
                end else begin
                    cnt_en  = 1'b1;
                    cnt_dir = 1'b0;
                    mode_d  = 1'b0;
                    state_d = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (cnt_val > lo_q) begin
                    cnt_en  = 1'b1;
                    cnt_dir = 1'b0;
                end else if (rem_q == 4'd1) begin
                    // Last requested sweep: park at lo.
                    rem_d   = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    // rem_q == 0 means free-running, so it must not wrap.
                    if (rem_q != 4'd0) begin
                        rem_d = rem_q - 4'd1;
                    end
                    cnt_en  = 1'b1;
                    cnt_dir = 1'b1;
                    mode_d  = 1'b1;
                    state_d = ST_UP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            rem_q   <= 4'd0;
            mode_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    assign q    = cnt_val;
    assign mode = mode_q;
    assign busy = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign done = (state_q == ST_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_bidir_sweep_ctrl.sv
// Directed bench for bidir_sweep_ctrl: vector table plus multi-cycle sequences.
module tb_bidir_sweep_ctrl;

    logic       clk = 1'b0;
    logic       clr, start, stop;
    logic [2:0] lo, hi;
    logic [3:0] cycles;
    logic [2:0] q;
    logic       mode, busy, done, err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bidir_sweep_ctrl #(.W(3)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .stop   (stop),
        .lo     (lo),
        .hi     (hi),
        .cycles (cycles),
        .q      (q),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    typedef struct {
        logic       clr, start, stop;
        logic [2:0] lo, hi;
        logic [3:0] cyc;
        logic [2:0] q;
        logic       mode, busy, done, err;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic c, input logic s, input logic p,
                                input logic [2:0] l, input logic [2:0] h, input logic [3:0] n,
                                input logic [2:0] eq, input logic em, input logic eb,
                                input logic ed, input logic ee);
        vec_t v;
        v.clr = c; v.start = s; v.stop = p; v.lo = l; v.hi = h; v.cyc = n;
        v.q = eq; v.mode = em; v.busy = eb; v.done = ed; v.err = ee;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int eq, input int em,
                           input int eb, input int ed, input int ee);
        chk({tag, ".q"},    int'(q),    eq);
        chk({tag, ".mode"}, int'(mode), em);
        chk({tag, ".busy"}, int'(busy), eb);
        chk({tag, ".done"}, int'(done), ed);
        chk({tag, ".err"},  int'(err),  ee);
    endtask

    initial begin
        int exp_q[$];
        int exp_m[$];
        int obs[$];
        int peaks;
        bit done_seen;
        int cnt;

        clr = 1'b1; start = 1'b0; stop = 1'b0; lo = '0; hi = '0; cycles = '0;

        //            clr start stop lo hi cyc | q  m  b  d  e
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);  // reset
        tbl[1]  = mk(0, 1, 0, 2, 5, 1,  2, 1, 1, 0, 0);  // accept 2..5 x1
        tbl[2]  = mk(0, 0, 0, 2, 5, 1,  3, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 7, 0,  4, 1, 1, 0, 0);  // bounds change ignored
        tbl[4]  = mk(0, 0, 0, 0, 7, 0,  5, 1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 7, 0,  4, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 7, 0,  3, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 7, 0,  2, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 7, 0,  2, 0, 0, 1, 0);  // done, q at lo
        tbl[9]  = mk(0, 0, 0, 0, 7, 0,  2, 0, 0, 0, 0);  // idle holds
        tbl[10] = mk(0, 1, 0, 6, 1, 1,  2, 0, 0, 0, 1);  // lo>hi rejected
        tbl[11] = mk(0, 0, 0, 6, 1, 1,  2, 0, 0, 0, 0);  // err one cycle only
        tbl[12] = mk(0, 1, 0, 3, 3, 1,  3, 1, 0, 1, 0);  // lo==hi straight to done
        tbl[13] = mk(0, 0, 0, 3, 3, 1,  3, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 3, 3, 1,  3, 1, 0, 0, 0);  // stop ignored in idle
        tbl[15] = mk(1, 1, 0, 1, 4, 1,  0, 1, 0, 0, 0);  // clr beats start
        tbl[16] = mk(0, 0, 0, 1, 4, 1,  0, 1, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            clr = tbl[i].clr; start = tbl[i].start; stop = tbl[i].stop;
            lo = tbl[i].lo; hi = tbl[i].hi; cycles = tbl[i].cyc;
            step();
            $display("vec %0d: clr=%0d start=%0d stop=%0d lo=%0d hi=%0d -> q=%0d mode=%0d busy=%0d done=%0d err=%0d",
                     i, clr, start, stop, lo, hi, q, mode, busy, done, err);
            chk_all($sformatf("vec%0d", i), int'(tbl[i].q), int'(tbl[i].mode),
                    int'(tbl[i].busy), int'(tbl[i].done), int'(tbl[i].err));
        end
        clr = 1'b0; start = 1'b0; stop = 1'b0;

        // Free-running 0..7 sweep, stopped at q=5 on the second descent.
        for (int v = 0; v <= 7; v++) begin exp_q.push_back(v); exp_m.push_back(1); end
        for (int v = 6; v >= 0; v--) begin exp_q.push_back(v); exp_m.push_back(0); end
        for (int v = 1; v <= 7; v++) begin exp_q.push_back(v); exp_m.push_back(1); end
        for (int v = 6; v >= 5; v--) begin exp_q.push_back(v); exp_m.push_back(0); end
        lo = 3'd0; hi = 3'd7; cycles = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) step();
            $display("free k=%0d q=%0d mode=%0d busy=%0d", k, q, mode, busy);
            chk_all($sformatf("free%0d", k), exp_q[k], exp_m[k], 1, 0, 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        $display("free stop: q=%0d done=%0d busy=%0d", q, done, busy);
        chk_all("free_stop", 5, 0, 0, 1, 0);
        step();
        $display("free idle: q=%0d done=%0d", q, done);
        chk_all("free_idle", 5, 0, 0, 0, 0);

        // Re-pulsed start ignored mid-run, then clr on the 4th busy cycle.
        lo = 3'd1; hi = 3'd2; cycles = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        $display("abort b1: q=%0d mode=%0d busy=%0d", q, mode, busy);
        chk_all("abort_b1", 1, 1, 1, 0, 0);
        step();
        chk_all("abort_b2", 2, 1, 1, 0, 0);
        start = 1'b1; lo = 3'd0; hi = 3'd3;
        step();
        start = 1'b0;
        $display("abort b3: q=%0d mode=%0d busy=%0d", q, mode, busy);
        chk_all("abort_b3", 1, 0, 1, 0, 0);
        step();
        $display("abort b4: q=%0d mode=%0d busy=%0d", q, mode, busy);
        chk_all("abort_b4", 2, 1, 1, 0, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        $display("abort clr: q=%0d mode=%0d busy=%0d done=%0d", q, mode, busy, done);
        chk_all("abort_clr", 0, 1, 0, 0, 0);
        step();
        chk_all("abort_after", 0, 1, 0, 0, 0);

        // Three 0->1->0 sweeps, bounded wait for done.
        lo = 3'd0; hi = 3'd1; cycles = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        done_seen = 1'b0;
        cnt = 0;
        while (cnt < 40 && !done_seen) begin
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (busy) obs.push_back(int'(q));
                step();
                cnt++;
            end
        end
        chk("three_done_seen", int'(done_seen), 1);
        if (done_seen) chk("three_done_q", int'(q), 0);
        peaks = 0;
        foreach (obs[k]) if (obs[k] == 1) peaks++;
        $display("three: busy cycles=%0d peaks=%0d", obs.size(), peaks);
        chk("three_peaks", peaks, 3);
        chk("three_len", obs.size(), 7);
        for (int k = 0; k < 7 && k < obs.size(); k++) begin
            chk($sformatf("three_q%0d", k), obs[k], k % 2);
        end
        step();
        chk("three_idle_done", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bidir_sweep_ctrl.md
BIDIR_SWEEP_CTRL -- requirements
Module: bidir_sweep_ctrl

Interface
REQ-001 Parameter: W, 3, counter width in bits.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: clr  in  1  reset; synchronous and active-high.
REQ-004 Port: start  in  1  request a sweep run; sampled only in IDLE.
REQ-005 Port: stop  in  1  abort the active run; sampled only in UP/DOWN.
REQ-006 Port: lo  in  W  lower sweep bound.
REQ-007 Port: hi  in  W  upper sweep bound.
REQ-008 Port: cycles  in  4  number of full up-down sweeps; 0 = run until stop.
REQ-009 Port: q  out  W  current count value.
REQ-010 Port: mode  out  1  direction; 1 = up, 0 = down.
REQ-011 Port: busy  out  1  high in UP and DOWN.
REQ-012 Port: done  out  1  one-cycle pulse, high only in DONE.
REQ-013 Port: err  out  1  one-cycle pulse on a rejected start.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, UP, DOWN, DONE.
REQ-015 On start=1 in IDLE with lo>hi, the block SHALL pulse err for the next cycle and remain in IDLE with q unchanged.
REQ-016 On start=1 in IDLE with lo<=hi, the block SHALL latch lo, hi and cycles.
REQ-017 On that accepted start, the block SHALL load q<=lo, set mode=1 and enter UP; q=lo and busy=1 are visible one cycle after start.
REQ-018 On an accepted start with lo==hi, the block SHALL load q<=lo and enter DONE directly.
REQ-019 In UP with q<hi, the block SHALL update q<=q+1.
REQ-020 In UP with q==hi, the block SHALL update q<=q-1, set mode=0 and enter DOWN.
REQ-021 In DOWN with q>lo, the block SHALL update q<=q-1.
REQ-022 In DOWN with q==lo, the block SHALL count one completed sweep.
REQ-023 When that completed sweep is the last one requested, the block SHALL enter DONE with q holding lo.
REQ-024 When more sweeps remain, or when cycles==0, the block SHALL update q<=q+1, set mode=1 and enter UP.
REQ-025 The remaining-sweep counter SHALL be 4 bits, decrement only on a completed sweep, and never wrap.
REQ-026 stop=1 in UP or DOWN SHALL take priority over any count step: q holds, and the next state is DONE.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 stop SHALL be ignored in IDLE and in DONE.
REQ-029 A change on lo, hi or cycles after acceptance SHALL have no effect on the active run.
REQ-030 DONE SHALL last exactly one cycle, assert done=1 and busy=0, then return to IDLE.
REQ-031 In IDLE, q and mode SHALL hold their last values.
REQ-032 q SHALL never leave the range [lo, hi] of the active run and SHALL never wrap modulo 2^W.

Reset
REQ-033 clr=1 at a rising edge SHALL force state to IDLE, q=0, mode=1, busy=0, done=0, err=0 and the sweep counter to 0.
REQ-034 clr SHALL take priority over start and stop in the same cycle.
REQ-035 clr during a run SHALL abort the run without a done pulse.

Structure
REQ-036 A shared package SHALL hold the state enumeration (IDLE, UP, DOWN, DONE) and the default width constant W=3.
REQ-037 The count datapath SHALL be one sub-module, updown_cnt, with ports clk, clr, load, load_val, en and mode.
REQ-038 updown_cnt SHALL count up on mode=1 and down on mode=0 when en=1; the FSM SHALL remain in bidir_sweep_ctrl.

Verification
REQ-039 Scenario lo=2, hi=5, cycles=1, start pulse: q SHALL read 2,3,4,5,4,3,2 with busy=1, then done=1 for one cycle with q=2, then IDLE.
REQ-040 Scenario lo=6, hi=1, start: err=1 for exactly one cycle, busy stays 0, q unchanged.
REQ-041 Scenario lo=0, hi=7, cycles=0, stop asserted while q=5 in DOWN: q holds 5, done pulses once, no wrap past 0 or 7 beforehand.
REQ-042 Scenario lo=3, hi=3, start: the next cycle SHALL show q=3 and done=1 with busy never high.
REQ-043 Scenario lo=1, hi=2, cycles=2, start re-pulsed mid-run and clr asserted at the 4th busy cycle: the re-pulsed start is ignored, and after clr the outputs read q=0, mode=1, busy=0 with no done pulse.
REQ-044 Scenario lo=0, hi=1, cycles=3: the bench SHALL observe exactly three lo->hi->lo sweeps before done.
